// File: rtl/pcie_lane_os_sched.sv
// pcie_lane_os_sched
// Per-lane transmit symbol scheduler. One symbol per clock is chosen from
// upper-layer data, logical idle, or an ordered set (TS1/TS2, SKP, FTS, EIOS)
// generated symbol by symbol. SKP sets are forced out periodically.
//
// Ports:
//   Clk, Reset                 symbol clock, asynchronous active-high reset
//   LinkNum/LinkPad            TS link field (PAD K23.7 when LinkPad)
//   LaneNum/LanePad            TS lane field (PAD K23.7 when LanePad)
//   NFts, DataRate, LinkCtrl   TS fields; NFts is also the FTS burst length
//   ReqTs, TsType              level request for continuous TS1/TS2
//   ReqFts, ReqEios            pulse requests, latched until served
//   TxData/TxDataCtl/TxValid/TxLast, TxReady   upper-layer symbol handshake
//   TxByte/TxControl           registered lane symbol and K flag
//   TxElecIdle                 registered electrical-idle indication
//   OsStart                    registered pulse on the COM of every set
module pcie_lane_os_sched #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKPW         = 11
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] LinkNum,
  input  logic       LinkPad,
  input  logic [4:0] LaneNum,
  input  logic       LanePad,
  input  logic [7:0] NFts,
  input  logic [7:0] DataRate,
  input  logic [7:0] LinkCtrl,
  input  logic       ReqTs,
  input  logic       TsType,
  input  logic       ReqFts,
  input  logic       ReqEios,
  input  logic [7:0] TxData,
  input  logic       TxDataCtl,
  input  logic       TxValid,
  input  logic       TxLast,
  output logic       TxReady,
  output logic [7:0] TxByte,
  output logic       TxControl,
  output logic       TxElecIdle,
  output logic       OsStart
);

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_TS1 = 8'h4A;
  localparam logic [7:0] SYM_TS2 = 8'h45;
  localparam logic [SKPW-1:0] SKP_MAX = SKPW'(SKP_INTERVAL);
  // The count reaches SKP_INTERVAL on the edge where this value is seen,
  // so the SKP is due on that same edge.
  localparam logic [SKPW-1:0] SKP_DUE = SKPW'(SKP_INTERVAL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_OS, ST_EIDLE} state_t;
  typedef enum logic [1:0] {OS_TS, OS_SKP, OS_FTS, OS_EIOS} os_t;

  state_t          state_r, state_s;
  os_t             kind_r, kind_s, pick_kind_s, pick_ei_kind_s, launch_kind_s;
  logic [3:0]      sym_r, sym_s;
  logic [SKPW-1:0] skp_cnt_r, skp_cnt_s;
  logic            fts_pend_r, fts_pend_s, eios_pend_r, eios_pend_s;
  logic [7:0]      fts_remain_r, fts_remain_s, fts_left_s;
  logic            skp_due_s, eios_req_s, fts_req_s;
  logic            pick_ok_s, pick_ei_ok_s, launch_s, os_last_s;
  logic [7:0]      byte_s, cont_byte_s;
  logic            ctl_s, cont_ctl_s, eidle_s, start_s, ready_s;
  logic [7:0]      ts_link_r, ts_lane_r, ts_nfts_r, ts_rate_r, ts_ctrl_r, ts_id_r;
  logic            ts_link_k_r, ts_lane_k_r;

  // Arbitration: what would win at a decision point this cycle.
  always_comb begin
    skp_due_s      = (state_r != ST_EIDLE) && (skp_cnt_r >= SKP_DUE);
    eios_req_s     = eios_pend_r | ReqEios;
    fts_req_s      = fts_pend_r | ReqFts;
    fts_left_s     = ReqFts ? NFts : fts_remain_r;
    pick_ok_s      = 1'b1;
    pick_kind_s    = OS_SKP;
    if (skp_due_s) begin
      pick_kind_s = OS_SKP;
    end else if (eios_req_s) begin
      pick_kind_s = OS_EIOS;
    end else if (fts_req_s) begin
      // An exhausted burst still owes its closing SKP.
      pick_kind_s = (fts_left_s != 8'd0) ? OS_FTS : OS_SKP;
    end else if (ReqTs) begin
      pick_kind_s = OS_TS;
    end else begin
      pick_ok_s = 1'b0;
    end
    // Only FTS or TS may wake the lane from electrical idle.
    pick_ei_ok_s   = fts_req_s | ReqTs;
    pick_ei_kind_s = OS_TS;
    if (fts_req_s) begin
      pick_ei_kind_s = (fts_left_s != 8'd0) ? OS_FTS : OS_SKP;
    end else begin
      pick_ei_kind_s = OS_TS;
    end
  end

  // Symbol following the current one inside an ordered set.
  always_comb begin
    cont_byte_s = SYM_SKP;
    cont_ctl_s  = 1'b1;
    os_last_s   = (kind_r == OS_TS) ? (sym_r == 4'd15) : (sym_r == 4'd3);
    case (kind_r)
      OS_TS: begin
        cont_ctl_s = 1'b0;
        case (sym_r + 4'd1)
          4'd1:    begin cont_byte_s = ts_link_r; cont_ctl_s = ts_link_k_r; end
          4'd2:    begin cont_byte_s = ts_lane_r; cont_ctl_s = ts_lane_k_r; end
          4'd3:    cont_byte_s = ts_nfts_r;
          4'd4:    cont_byte_s = ts_rate_r;
          4'd5:    cont_byte_s = ts_ctrl_r;
          default: cont_byte_s = ts_id_r;
        endcase
      end
      OS_SKP:  cont_byte_s = SYM_SKP;
      OS_FTS:  cont_byte_s = SYM_FTS;
      OS_EIOS: cont_byte_s = SYM_IDL;
      default: cont_byte_s = SYM_SKP;
    endcase
  end

  // Next state, next lane symbol and request/counter bookkeeping.
  always_comb begin
    state_s       = state_r;
    kind_s        = kind_r;
    sym_s         = sym_r;
    byte_s        = 8'h00;
    ctl_s         = 1'b0;
    eidle_s       = 1'b0;
    start_s       = 1'b0;
    launch_s      = 1'b0;
    launch_kind_s = OS_SKP;
    case (state_r)
      ST_IDLE: begin
        // A symbol already offered TxReady is taken even if a request just arrived.
        if (TxReady && TxValid) begin
          state_s = TxLast ? ST_IDLE : ST_DATA;
          byte_s  = TxData;
          ctl_s   = TxDataCtl;
        end else if (pick_ok_s) begin
          launch_s      = 1'b1;
          launch_kind_s = pick_kind_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (TxValid) begin
          state_s = TxLast ? ST_IDLE : ST_DATA;
          byte_s  = TxData;
          ctl_s   = TxDataCtl;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_OS: begin
        if (!os_last_s) begin
          sym_s  = sym_r + 4'd1;
          byte_s = cont_byte_s;
          ctl_s  = cont_ctl_s;
        end else if (kind_r == OS_EIOS) begin
          state_s = ST_EIDLE;
          eidle_s = 1'b1;
        end else if (pick_ok_s) begin
          launch_s      = 1'b1;
          launch_kind_s = pick_kind_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EIDLE: begin
        if (pick_ei_ok_s) begin
          launch_s      = 1'b1;
          launch_kind_s = pick_ei_kind_s;
        end else begin
          eidle_s = 1'b1;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    if (launch_s) begin
      state_s = ST_OS;
      kind_s  = launch_kind_s;
      sym_s   = 4'd0;
      byte_s  = SYM_COM;
      ctl_s   = 1'b1;
      start_s = 1'b1;
      eidle_s = 1'b0;
    end else begin
      start_s = 1'b0;
    end

    fts_pend_s   = fts_req_s;
    fts_remain_s = fts_left_s;
    eios_pend_s  = (state_r == ST_EIDLE) ? 1'b0 : eios_req_s;
    if (state_r == ST_EIDLE) begin
      skp_cnt_s = '0;
    end else if (skp_cnt_r < SKP_MAX) begin
      skp_cnt_s = skp_cnt_r + {{(SKPW-1){1'b0}}, 1'b1};
    end else begin
      skp_cnt_s = skp_cnt_r;
    end
    if (launch_s) begin
      case (launch_kind_s)
        OS_SKP: begin
          skp_cnt_s = '0;
          // Any SKP sent once the burst is used up closes the FTS request.
          if (fts_left_s == 8'd0) fts_pend_s = 1'b0;
          else                    fts_pend_s = fts_req_s;
        end
        OS_FTS:  fts_remain_s = fts_left_s - 8'd1;
        OS_EIOS: eios_pend_s  = 1'b0;
        default: eios_pend_s  = eios_pend_s;
      endcase
    end else begin
      eios_pend_s = eios_pend_s;
    end

    // TxReady is registered, so predict whether IDLE would give the lane away.
    ready_s = (state_s == ST_DATA) ||
              ((state_s == ST_IDLE) &&
               !((skp_cnt_s >= SKP_DUE) || eios_pend_s || fts_pend_s || ReqTs));
  end

  // State, counters, latched requests and registered lane outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      kind_r       <= OS_TS;
      sym_r        <= 4'd0;
      skp_cnt_r    <= '0;
      fts_pend_r   <= 1'b0;
      fts_remain_r <= 8'd0;
      eios_pend_r  <= 1'b0;
      TxByte       <= 8'h00;
      TxControl    <= 1'b0;
      TxElecIdle   <= 1'b0;
      OsStart      <= 1'b0;
      TxReady      <= 1'b0;
    end else begin
      state_r      <= state_s;
      kind_r       <= kind_s;
      sym_r        <= sym_s;
      skp_cnt_r    <= skp_cnt_s;
      fts_pend_r   <= fts_pend_s;
      fts_remain_r <= fts_remain_s;
      eios_pend_r  <= eios_pend_s;
      TxByte       <= byte_s;
      TxControl    <= ctl_s;
      TxElecIdle   <= eidle_s;
      OsStart      <= start_s;
      TxReady      <= ready_s;
    end
  end

  // TS fields captured at COM so every symbol of one set is consistent.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ts_link_r   <= 8'h00;
      ts_link_k_r <= 1'b0;
      ts_lane_r   <= 8'h00;
      ts_lane_k_r <= 1'b0;
      ts_nfts_r   <= 8'h00;
      ts_rate_r   <= 8'h00;
      ts_ctrl_r   <= 8'h00;
      ts_id_r     <= 8'h00;
    end else if (launch_s && (launch_kind_s == OS_TS)) begin
      ts_link_r   <= LinkPad ? SYM_PAD : LinkNum;
      ts_link_k_r <= LinkPad;
      ts_lane_r   <= LanePad ? SYM_PAD : {3'b000, LaneNum};
      ts_lane_k_r <= LanePad;
      ts_nfts_r   <= NFts;
      ts_rate_r   <= DataRate;
      ts_ctrl_r   <= LinkCtrl;
      ts_id_r     <= TsType ? SYM_TS2 : SYM_TS1;
    end
  end

endmodule

// File: doc/pcie_lane_os_sched.md
# pcie_lane_os_sched

Per-lane transmit symbol scheduler for the PCI Express link model. It arbitrates one byte-per-clock lane between upper-layer data and the physical-layer ordered sets: TS1/TS2, FTS, SKP and electrical-idle (EIOS). It generates each ordered set symbol by symbol and enforces periodic SKP insertion. Its TxByte/TxControl output feeds the lane encoder/scrambler, and is the stream the lane receive/display logic later decodes.

## Interface
Parameters:
- SKP_INTERVAL, 1180: symbol times between SKP ordered sets; minimum legal value 8.
- SKPW, 11: width of the SKP interval counter; must hold SKP_INTERVAL.

Ports:
- Clk  input  1  lane symbol clock; one symbol per cycle.
- Reset  input  1  asynchronous, active-high reset.
- LinkNum  input  8  TS link-number field.
- LinkPad  input  1  1 = send PAD (K23.7, 8'hF7, control) in place of LinkNum.
- LaneNum  input  5  TS lane-number field, zero-extended to 8 bits.
- LanePad  input  1  1 = send PAD in place of LaneNum.
- NFts  input  8  TS N_FTS field; also the FTS burst length.
- DataRate  input  8  TS data-rate field.
- LinkCtrl  input  8  TS link-control field.
- ReqTs  input  1  level; send TS continuously while high.
- TsType  input  1  0 = TS1 (ID 8'h4A), 1 = TS2 (ID 8'h45).
- ReqFts  input  1  pulse; request an FTS burst.
- ReqEios  input  1  pulse; request EIOS followed by electrical idle.
- TxData  input  8  upper-layer symbol.
- TxDataCtl  input  1  TxData is a K symbol.
- TxValid  input  1  TxData valid.
- TxLast  input  1  final symbol of a packet.
- TxReady  output  1  TxData is accepted this cycle when TxValid is also high.
- TxByte  output  8  registered lane symbol.
- TxControl  output  1  registered K-symbol flag.
- TxElecIdle  output  1  registered; lane is in electrical idle.
- OsStart  output  1  one-cycle pulse coincident with the COM of every ordered set.

## Operation
- States: IDLE, DATA, OS, EIDLE.
- OS symbol layout (sym counter 0..N-1):
  - TS, 16 symbols: COM (8'hBC, K), link, lane, NFts, DataRate, LinkCtrl, then 10 ID symbols.
  - SKP, 4 symbols: COM, then 3 × 8'h1C (K).
  - FTS, 4 symbols: COM, then 3 × 8'h3C (K).
  - EIOS, 4 symbols: COM, then 3 × 8'h7C (K).
  - TS field values (LinkCtrl, link/lane/PAD selection, TsType) are sampled at COM and held for the whole set.
- Decision points: every cycle in IDLE or EIDLE, the last symbol of an OS, and the accepted TxLast symbol. A started ordered set or packet is never interrupted.
- Priority at a decision point:
  1. SKP pending.
  2. EIOS pending.
  3. FTS burst remaining.
  4. ReqTs.
  5. Data: TxValid in IDLE.
  6. Logical idle: 8'h00, data.
- SKP counter:
  - Increments every non-EIDLE cycle.
  - Sets SkpPending at SKP_INTERVAL and saturates there.
  - Cleared to 0 on the COM of a SKP.
  - Held at 0 in EIDLE.
- FTS: a ReqFts pulse latches FtsRemain = NFts. That many FTS sets are sent back-to-back, then one mandatory SKP. NFts = 0 sends only the SKP.
- ReqFts or ReqEios arriving while busy is latched. A repeat request before service is merged.
- EIOS: after the last IDL symbol the block enters EIDLE.
  - TxElecIdle = 1, TxByte = 0, TxControl = 0, TxReady = 0.
  - ReqTs or a latched FTS request leaves EIDLE. TxElecIdle drops in the same cycle the COM appears.
- DATA: TxReady = 1 until TxLast is accepted. A TxValid low gap inside a packet emits 8'h00 data and stays in DATA.
- TxReady in IDLE is 1 only when no SKP/EIOS/FTS/TS request wins.
- Reset (asynchronous, any state, including mid-OS or mid-packet):
  - State = IDLE.
  - All counters and latched requests = 0.
  - Outputs TxByte = 0, TxControl = 0, TxElecIdle = 0, TxReady = 0, OsStart = 0.
  - TxReady is first asserted one cycle after reset release.

## Timing
- All outputs are registered.
- Request latency: a request winning at edge N puts its COM on TxByte after edge N, with OsStart = 1.
- Data: TxValid & TxReady at edge N puts TxData on TxByte after edge N; latency 1.
- Back-to-back: the last OS symbol at cycle k is followed by the next COM at cycle k+1, with no gap.
- Simultaneous SKP threshold and TxLast acceptance: the SKP COM follows immediately in the next cycle.
- SKP delay bound: a SKP is delayed only by the remainder of the current OS (≤ 15 cycles) or the current packet.

## Test plan
- Reset release, no requests, SKP_INTERVAL = 32 -> TxByte = 00 for 32 cycles, then BC 1C 1C 1C, with OsStart on BC and repeating at the same period.
- ReqTs = 1, TsType = 0, LinkPad = 1, LaneNum = 3, NFts = 8'h18, DataRate = 8'h02, LinkCtrl = 0 -> BC F7(K) 03 18 02 00 followed by 4A × 10; continuous while ReqTs is high.
- ReqFts with NFts = 3 -> three consecutive BC 3C 3C 3C sets, then BC 1C 1C 1C, then 00 idle.
- A 6-symbol packet whose first symbol is accepted with the SKP counter at 30 (interval 32) -> all 6 symbols are contiguous, and SKP COM appears the cycle after TxLast.
- ReqEios pulse during a TS -> the TS completes, then BC 7C 7C 7C, then TxElecIdle = 1 and TxReady = 0. A later ReqTs gives TxElecIdle = 0 coincident with BC.
- Reset asserted at TS symbol 7 -> TxByte = 0 and TxControl = 0 immediately, without waiting for a clock edge. After release with ReqTs held, a fresh TS starts at COM.
